// File: rtl/mlp_layer_sequencer.sv
// Control sequencer for one fully connected MLP layer: streams weight/input reads
// and drives the accumulate, ReLU and output-write strobes of the datapath.
module mlp_layer_sequencer #(
  parameter int NUM_IN  = 16,
  parameter int NUM_OUT = 16,
  parameter int AW      = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    bank_ready,
  output logic          busy,
  output logic          done,
  output logic          bank_sel,
  output logic          bank_release,
  output logic          w_rd_en,
  output logic [AW-1:0] w_rd_addr,
  output logic          x_rd_en,
  output logic [AW-1:0] x_rd_addr,
  output logic          acc_en,
  output logic          acc_first,
  output logic          relu_ld,
  output logic          out_wr_en,
  output logic [AW-1:0] out_addr
);

  typedef enum logic [1:0] {IDLE, WAIT_BANK, FETCH, DRAIN} state_t;

  localparam logic [AW-1:0] K_LAST = AW'(NUM_IN - 1);
  localparam logic [AW-1:0] J_LAST = AW'(NUM_OUT - 1);
  localparam logic [AW-1:0] ONE    = AW'(1);

  state_t        state;
  logic [AW-1:0] j;
  logic          bank_seen;
  logic [2:0]    drain_cnt;

  // x_rd_addr doubles as the k counter; w_rd_addr is a running linear counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      j            <= '0;
      bank_seen    <= 1'b0;
      drain_cnt    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      bank_sel     <= 1'b0;
      bank_release <= 1'b0;
      w_rd_en      <= 1'b0;
      x_rd_en      <= 1'b0;
      w_rd_addr    <= '0;
      x_rd_addr    <= '0;
    end else begin
      bank_release <= 1'b0;
      done         <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            bank_seen <= 1'b0;
            if (bank_ready[bank_sel]) begin
              state   <= FETCH;
              w_rd_en <= 1'b1;
              x_rd_en <= 1'b1;
            end else begin
              state <= WAIT_BANK;
            end
          end
        end
        WAIT_BANK: begin
          if (bank_seen) begin
            state   <= FETCH;
            w_rd_en <= 1'b1;
            x_rd_en <= 1'b1;
          end else begin
            bank_seen <= bank_ready[bank_sel];
          end
        end
        FETCH: begin
          if (x_rd_addr == K_LAST) begin
            x_rd_addr <= '0;
            if (j == J_LAST) begin
              state        <= DRAIN;
              w_rd_en      <= 1'b0;
              x_rd_en      <= 1'b0;
              w_rd_addr    <= '0;
              j            <= '0;
              bank_release <= 1'b1;
              bank_sel     <= ~bank_sel;
              drain_cnt    <= '0;
            end else begin
              j         <= j + ONE;
              w_rd_addr <= w_rd_addr + ONE;
            end
          end else begin
            x_rd_addr <= x_rd_addr + ONE;
            w_rd_addr <= w_rd_addr + ONE;
          end
        end
        DRAIN: begin
          drain_cnt <= drain_cnt + 3'd1;
          // Last output write lands 3 cycles into DRAIN; done follows it.
          if (drain_cnt == 3'd3) done <= 1'b1;
          if (drain_cnt == 3'd4) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic          en_d1;
  logic          first_d1;
  logic          last_d1;
  logic          last_d2;
  logic [AW-1:0] j_d1;
  logic [AW-1:0] j_d2;
  logic [AW-1:0] j_d3;

  // Strobe delay line matching SRAM, multiplier and accumulator latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      en_d1     <= 1'b0;
      first_d1  <= 1'b0;
      last_d1   <= 1'b0;
      last_d2   <= 1'b0;
      j_d1      <= '0;
      j_d2      <= '0;
      j_d3      <= '0;
      acc_en    <= 1'b0;
      acc_first <= 1'b0;
      relu_ld   <= 1'b0;
      out_wr_en <= 1'b0;
      out_addr  <= '0;
    end else begin
      en_d1     <= w_rd_en;
      first_d1  <= w_rd_en && (x_rd_addr == '0);
      last_d1   <= w_rd_en && (x_rd_addr == K_LAST);
      last_d2   <= last_d1;
      j_d1      <= j;
      j_d2      <= j_d1;
      j_d3      <= j_d2;
      acc_en    <= en_d1;
      acc_first <= first_d1;
      relu_ld   <= last_d2;
      out_wr_en <= relu_ld;
      out_addr  <= j_d3;
    end
  end

endmodule
